// File: rtl/approx_mult_engine.sv
// Streaming approximate multiplier: normalise, multiply the top KEEP_W bits, then denormalise.
// Optional sticky rounding of the kept fields is enabled by defining APPROX_ROUND_EN.
module approx_mult_engine #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned KEEP_W = 8
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                in_valid_i,
   output logic                in_ready_o,
   input  logic [DATA_W-1:0]   in_a_i,
   input  logic [DATA_W-1:0]   in_b_i,
   output logic                out_valid_o,
   input  logic                out_ready_i,
   output logic [2*DATA_W-1:0] out_p_o,
   output logic                out_zero_o,
   output logic                busy_o
);

   localparam int unsigned CNT_W = $clog2(2 * DATA_W);
   localparam int unsigned DROP_W = DATA_W - KEEP_W;

   typedef enum logic [2:0] {StIdle, StNorm, StMult, StDenorm, StDone} state_e;

   state_e                state_q, state_d;
   logic [DATA_W-1:0]     ra_q, ra_d, rb_q, rb_d;
   logic [CNT_W-1:0]      sa_q, sa_d, sb_q, sb_d, rem_q, rem_d;
   logic [2*DATA_W-1:0]   prod_q, prod_d, out_p_q, out_p_d;
   logic                  out_zero_q, out_zero_d;
   logic [KEEP_W-1:0]     keep_a, keep_b;
   logic [2*KEEP_W-1:0]   keep_p;

   // Kept fields of the normalised operands; sticky mode jams the discarded bits into the LSB.
   always_comb begin
      keep_a = ra_q[DATA_W-1 -: KEEP_W];
      keep_b = rb_q[DATA_W-1 -: KEEP_W];
`ifdef APPROX_ROUND_EN
      keep_a[0] = keep_a[0] | (|ra_q[DROP_W-1:0]);
      keep_b[0] = keep_b[0] | (|rb_q[DROP_W-1:0]);
`endif
      keep_p = {{KEEP_W{1'b0}}, keep_a} * {{KEEP_W{1'b0}}, keep_b};
   end

   always_comb begin
      state_d    = state_q;
      ra_d       = ra_q;
      rb_d       = rb_q;
      sa_d       = sa_q;
      sb_d       = sb_q;
      rem_d      = rem_q;
      prod_d     = prod_q;
      out_p_d    = out_p_q;
      out_zero_d = out_zero_q;
      case (state_q)
         StIdle: begin
            if (in_valid_i) begin
               ra_d       = in_a_i;
               rb_d       = in_b_i;
               sa_d       = '0;
               sb_d       = '0;
               out_zero_d = 1'b0;
               state_d    = StNorm;
            end
         end
         StNorm: begin
            if (ra_q == '0 || rb_q == '0) begin
               out_p_d    = '0;
               out_zero_d = 1'b1;
               state_d    = StDone;
            end else if (ra_q[DATA_W-1] && rb_q[DATA_W-1]) begin
               state_d = StMult;
            end else begin
               if (!ra_q[DATA_W-1]) begin
                  ra_d = ra_q << 1;
                  sa_d = sa_q + CNT_W'(1);
               end
               if (!rb_q[DATA_W-1]) begin
                  rb_d = rb_q << 1;
                  sb_d = sb_q + CNT_W'(1);
               end
            end
         end
         StMult: begin
            prod_d  = {keep_p, {(2 * DROP_W){1'b0}}};
            rem_d   = sa_q + sb_q;
            state_d = StDenorm;
         end
         StDenorm: begin
            if (rem_q == '0) begin
               out_p_d = prod_q;
               state_d = StDone;
            end else begin
               prod_d = prod_q >> 1;
               rem_d  = rem_q - CNT_W'(1);
            end
         end
         StDone: begin
            if (out_ready_i) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= StIdle;
         ra_q       <= '0;
         rb_q       <= '0;
         sa_q       <= '0;
         sb_q       <= '0;
         rem_q      <= '0;
         prod_q     <= '0;
         out_p_q    <= '0;
         out_zero_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         ra_q       <= ra_d;
         rb_q       <= rb_d;
         sa_q       <= sa_d;
         sb_q       <= sb_d;
         rem_q      <= rem_d;
         prod_q     <= prod_d;
         out_p_q    <= out_p_d;
         out_zero_q <= out_zero_d;
      end
   end

   assign in_ready_o  = (state_q == StIdle);
   assign out_valid_o = (state_q == StDone);
   assign busy_o      = (state_q != StIdle);
   assign out_p_o     = out_p_q;
   assign out_zero_o  = out_zero_q;

endmodule
